// File: rtl/dot_seq_ctrl_if.sv
// Bundle for dot_seq_ctrl: job control, operand stream, shared-MAC hookup and result handshake.
// slave is the sequencer side; master is the job source / operand feeder / MAC / result sink.
interface dot_seq_ctrl_if;
  logic        start;
  logic [7:0]  len;
  logic        mode;
  logic        busy;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;

  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [15:0] mac_c;
  logic        mac_mode;
  logic [15:0] mac_out;
  logic        mac_err;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;

  modport slave (
    input  start, len, mode, in_valid, in_a, in_b, mac_out, mac_err, res_ready,
    output busy, in_ready, mac_a, mac_b, mac_c, mac_mode, res_valid, res_data, res_err
  );

  modport master (
    output start, len, mode, in_valid, in_a, in_b, mac_out, mac_err, res_ready,
    input  busy, in_ready, mac_a, mac_b, mac_c, mac_mode, res_valid, res_data, res_err
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Dot-product sequencer driving a shared external MAC; accumulates len products, then offers one result.
// Define MAC_PIPE_EN when the MAC has a 1-cycle registered result (adds a WAIT state per element).
module dot_seq_ctrl (
  input  logic          clk,
  input  logic          rst,
  dot_seq_ctrl_if.slave bus
);

`ifdef MAC_PIPE_EN
  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
`endif

  state_e      state_q;
  logic [15:0] acc_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic [7:0]  len_q;
  logic        mode_q;
  logic        busy_q;
  logic        in_ready_q;
  logic        res_valid_q;

  logic        err_d;
  logic [7:0]  cnt_d;

  assign err_d = err_q | bus.mac_err;
  assign cnt_d = cnt_q + 8'd1;

  // MAC operands are pure wiring; outputs are forced quiet while reset is held.
  assign bus.mac_a     = bus.in_a;
  assign bus.mac_b     = bus.in_b;
  assign bus.mac_c     = rst ? 16'h0000 : acc_q;
  assign bus.mac_mode  = mode_q;
  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.busy      = busy_q & ~rst;
  assign bus.res_valid = res_valid_q & ~rst;
  assign bus.res_data  = rst ? 16'h0000 : acc_q;
  assign bus.res_err   = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= 16'h0000;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            mode_q <= bus.mode;
            acc_q  <= 16'h0000;
            err_q  <= 1'b0;
            cnt_q  <= 8'd0;
            busy_q <= 1'b1;
            // An empty job goes straight to DONE with a zero result.
            if (bus.len == 8'd0) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.in_valid) begin
            cnt_q <= cnt_d;
`ifdef MAC_PIPE_EN
            state_q    <= WAIT;
            in_ready_q <= 1'b0;
`else
            acc_q <= bus.mac_out;
            err_q <= err_d;
            if (cnt_q == len_q - 8'd1) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
            end
`endif
          end
        end

`ifdef MAC_PIPE_EN
        // Registered MAC result for the element transferred last cycle lands here.
        WAIT: begin
          acc_q <= bus.mac_out;
          err_q <= err_d;
          if (cnt_q == len_q) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end else begin
            state_q    <= RUN;
            in_ready_q <= 1'b1;
          end
        end
`endif

        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
